// File: rtl/return_stack_pkg.sv
// +----------------------------------------------------------------------+
// | return_stack_pkg : shared PC/stack constants and stack op encoding   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package return_stack_pkg;

  localparam int PC_WIDTH     = 10;
  localparam int RSTACK_DEPTH = 16;

  // Opcodes the decoder maps onto push/pop; kept here so both sides agree.
  localparam logic [5:0] RS_OPC_PUSH = 6'b111000;
  localparam logic [5:0] RS_OPC_POP  = 6'b111100;

  typedef enum logic [1:0] {
    STK_IDLE = 2'b00,
    STK_POP  = 2'b01,
    STK_PUSH = 2'b10,
    STK_REPL = 2'b11
  } stack_op_e;

endpackage

`default_nettype wire

// File: rtl/stack_mem.sv
// +----------------------------------------------------------------------+
// | stack_mem : DEPTH x WIDTH register array, sync write / async read    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module stack_mem #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/return_stack.sv
// +----------------------------------------------------------------------+
// | return_stack : subroutine return-address LIFO with sticky error flags|
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module return_stack
  import return_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = RSTACK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W:0]   sp_q, sp_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             w_we;
  logic [PTR_W-1:0] w_waddr;
  logic [PTR_W:0]   w_sp_m1;
  logic [WIDTH-1:0] w_rdata;
  stack_op_e        w_op;

  assign w_op    = stack_op_e'({push, pop});
  assign w_sp_m1 = sp_q - (PTR_W+1)'(1);
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == (PTR_W+1)'(DEPTH));
  assign count   = sp_q;

  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    w_we        = 1'b0;
    w_waddr     = sp_q[PTR_W-1:0];
    unique case (w_op)
      STK_PUSH: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          w_we = 1'b1;
          sp_d = sp_q + (PTR_W+1)'(1);
        end
      end
      STK_POP: begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          sp_d = w_sp_m1;
        end
      end
      STK_REPL: begin
        // Overwrite the top in place; on an empty stack this degrades to a push.
        w_we = 1'b1;
        if (empty) begin
          w_waddr     = '0;
          sp_d        = (PTR_W+1)'(1);
          underflow_d = 1'b1;
        end else begin
          w_waddr = w_sp_m1[PTR_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (w_we & ~reset),
    .waddr(w_waddr),
    .wdata(din),
    .raddr(w_sp_m1[PTR_W-1:0]),
    .rdata(w_rdata)
  );

  assign dout      = empty ? '0 : w_rdata;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_return_stack.sv
// +----------------------------------------------------------------------+
// | tb_return_stack : directed + random checks against a queue model     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_return_stack;

  localparam int W = 10;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset, push, pop;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         empty, full, overflow, underflow;
  logic [4:0]   count;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] stk[$];
  bit           m_ovf, m_unf;

  always #5 clk = ~clk;

  return_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (din),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_top();
    return (stk.size() > 0) ? stk[stk.size()-1] : '0;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".dout"},  32'(dout),      32'(m_top()));
    chk({tag, ".count"}, 32'(count),     32'(stk.size()));
    chk({tag, ".empty"}, 32'(empty),     32'(stk.size() == 0));
    chk({tag, ".full"},  32'(full),      32'(stk.size() == D));
    chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, ".unf"},   32'(underflow), 32'(m_unf));
  endtask

  // One clock: outputs checked before the edge (return value visible in the
  // pop cycle) and again after the model has applied the same operation.
  task automatic cyc(input logic r, input logic p, input logic q, input logic [W-1:0] d);
    reset = r; push = p; pop = q; din = d;
    #1;
    if (!r) begin
      vectors++;
      assert (!$isunknown({push, pop})) else begin
        miscompares++;
        $error("FAIL ctrl_known observed=%b expected=known", {push, pop});
      end
    end
    chk_model("pre");
    @(posedge clk);
    if (r) begin
      stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (p && !q) begin
      if (stk.size() < D) stk.push_back(d); else m_ovf = 1;
    end else if (q && !p) begin
      if (stk.size() > 0) void'(stk.pop_back()); else m_unf = 1;
    end else if (p && q) begin
      if (stk.size() > 0) stk[stk.size()-1] = d;
      else begin stk.push_back(d); m_unf = 1; end
    end
    #1;
    chk_model("post");
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
    m_ovf = 0; m_unf = 0;
    @(posedge clk); #1;
    do_reset();
    repeat (3) cyc(0, 0, 0, '0);
    chk("rst.empty", 32'(empty), 1); chk("rst.count", 32'(count), 0);
    chk("rst.dout", 32'(dout), 0);   chk("rst.flags", 32'({overflow, underflow, full}), 0);

    // Basic LIFO order
    cyc(0, 1, 0, 10'h005); cyc(0, 1, 0, 10'h012); cyc(0, 1, 0, 10'h3FF);
    chk("p3.count", 32'(count), 3); chk("p3.dout", 32'(dout), 32'h3FF);
    chk("pop1.dout", 32'(dout), 32'h3FF); cyc(0, 0, 1, '0);
    chk("pop2.dout", 32'(dout), 32'h012); cyc(0, 0, 1, '0);
    chk("pop3.dout", 32'(dout), 32'h005); cyc(0, 0, 1, '0);
    chk("pop.empty", 32'(empty), 1); chk("pop.flags", 32'({overflow, underflow}), 0);

    // Fill and overflow
    for (int i = 0; i < D; i++) cyc(0, 1, 0, 10'(32'h100 + i));
    cyc(0, 1, 0, 10'h2AA);
    chk("ovf.full", 32'(full), 1); chk("ovf.count", 32'(count), 16);
    chk("ovf.dout", 32'(dout), 32'h10F); chk("ovf.flag", 32'(overflow), 1);
    chk("ovf.pop_dout", 32'(dout), 32'h10F); cyc(0, 0, 1, '0);
    chk("ovf.pop_count", 32'(count), 15);

    // Underflow, then replace
    do_reset();
    cyc(0, 0, 1, '0);
    chk("unf.flag", 32'(underflow), 1); chk("unf.count", 32'(count), 0);
    chk("unf.dout", 32'(dout), 0);
    cyc(0, 1, 0, 10'h001); cyc(0, 1, 1, 10'h077);
    chk("repl.count", 32'(count), 1); chk("repl.dout", 32'(dout), 32'h077);

    // Replace while full keeps overflow clear
    do_reset();
    for (int i = 0; i < D; i++) cyc(0, 1, 0, 10'(32'h200 + i));
    cyc(0, 1, 1, 10'h055);
    chk("frep.count", 32'(count), 16); chk("frep.dout", 32'(dout), 32'h055);
    chk("frep.ovf", 32'(overflow), 0);

    // Replace on empty acts as push and flags underflow
    do_reset();
    cyc(0, 1, 1, 10'h123);
    chk("erep.count", 32'(count), 1); chk("erep.dout", 32'(dout), 32'h123);
    chk("erep.unf", 32'(underflow), 1);

    // Reset beats a concurrent push
    do_reset();
    cyc(0, 1, 0, 10'h0A0); cyc(0, 1, 0, 10'h0B0);
    for (int i = 0; i < D - 1; i++) cyc(0, 1, 0, 10'(i));
    chk("rp.ovf_set", 32'(overflow), 1);
    cyc(1, 1, 0, 10'h3AB);
    chk("rp.count", 32'(count), 0); chk("rp.empty", 32'(empty), 1);
    chk("rp.flags", 32'({overflow, underflow}), 0); chk("rp.dout", 32'(dout), 0);

    // Random traffic, occasional reset
    for (int n = 0; n < 600; n++) begin
      automatic int sel = int'($urandom_range(0, 99));
      automatic logic r = (sel < 2);
      automatic logic p = (sel >= 2 && sel < 50) || (sel >= 85);
      automatic logic q = (sel >= 50);
      cyc(r, p, q, 10'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
